// File: rtl/tid_scheduler_if.sv
// tid_scheduler_if: requester/response bus of the TID scheduler.
//   master: requesters + response source (drive req_*, rsp_*; observe grants/status)
//   slave : the scheduler (drives req_ready, grant_tid, outstanding, pool flags, error)
interface tid_scheduler_if #(
  parameter int unsigned NUM_TID   = 16,
  parameter int unsigned TID_WIDTH = 4
);
  logic [1:0]           req_valid;
  logic [1:0]           req0_len;
  logic [1:0]           req1_len;
  logic [1:0]           req_ready;
  logic [TID_WIDTH-1:0] grant_tid;
  logic                 rsp_valid;
  logic [TID_WIDTH-1:0] rsp_tid;
  logic [TID_WIDTH:0]   outstanding;
  logic                 pool_full;
  logic                 pool_empty;
  logic                 err_unexp_rsp;

  modport master (
    output req_valid, req0_len, req1_len, rsp_valid, rsp_tid,
    input  req_ready, grant_tid, outstanding, pool_full, pool_empty, err_unexp_rsp
  );

  modport slave (
    input  req_valid, req0_len, req1_len, rsp_valid, rsp_tid,
    output req_ready, grant_tid, outstanding, pool_full, pool_empty, err_unexp_rsp
  );
endinterface

// File: rtl/tid_scheduler.sv
// tid_scheduler: allocates transaction IDs from a pool to two requesters with
// round-robin arbitration and frees each TID after its expected response lines.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tid_scheduler_if.slave (requests, grants, responses, pool status)
module tid_scheduler #(
  parameter int unsigned NUM_TID   = 16,
  parameter int unsigned TID_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  tid_scheduler_if.slave  bus
);

  localparam int unsigned OUT_W = TID_WIDTH + 1;
  localparam int unsigned CNT_W = 3;

  logic [NUM_TID-1:0]   busy;
  logic [CNT_W-1:0]     cnt [NUM_TID];
  logic [OUT_W-1:0]     outstanding_q;
  logic                 err_q;
  logic                 last_q;       // requester granted on the last transfer

  logic [TID_WIDTH-1:0] free_tid;
  logic [1:0]           ready;
  logic                 full;
  logic                 xfer;
  logic                 xfer_req;
  logic [1:0]           xfer_len;
  logic                 rsp_hit;
  logic                 rsp_final;
  logic                 rsp_miss;

  // Lowest-index free TID, from registered busy only
  always_comb begin
    free_tid = '0;
    for (int i = int'(NUM_TID) - 1; i >= 0; i--) begin
      if (!busy[i]) free_tid = TID_WIDTH'(i);
    end
  end

  assign full = (outstanding_q == OUT_W'(NUM_TID));

  // Round-robin arbitration; a tie goes to the requester not granted last
  always_comb begin
    ready = 2'b00;
    if (!rst && !full) begin
      case (bus.req_valid)
        2'b01:   ready = 2'b01;
        2'b10:   ready = 2'b10;
        2'b11:   ready = last_q ? 2'b01 : 2'b10;
        default: ready = 2'b00;
      endcase
    end
  end

  assign xfer     = |(bus.req_valid & ready);
  assign xfer_req = ready[1];
  assign xfer_len = xfer_req ? bus.req1_len : bus.req0_len;

  // A freshly granted TID is never busy, so a response and a grant never collide
  assign rsp_hit   = bus.rsp_valid && busy[bus.rsp_tid];
  assign rsp_final = rsp_hit && (cnt[bus.rsp_tid] == CNT_W'(1));
  assign rsp_miss  = bus.rsp_valid && !busy[bus.rsp_tid];

  // Per-TID state, occupancy count, sticky error and arbitration pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      for (int i = 0; i < int'(NUM_TID); i++) cnt[i] <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      last_q        <= 1'b1;
    end else begin
      if (rsp_hit) begin
        cnt[bus.rsp_tid] <= cnt[bus.rsp_tid] - CNT_W'(1);
        if (rsp_final) busy[bus.rsp_tid] <= 1'b0;
      end
      if (rsp_miss) err_q <= 1'b1;
      if (xfer) begin
        busy[free_tid] <= 1'b1;
        cnt[free_tid]  <= CNT_W'(xfer_len) + CNT_W'(1);
        last_q         <= xfer_req;
      end
      case ({xfer, rsp_final})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.grant_tid     = free_tid;
  assign bus.outstanding   = outstanding_q;
  assign bus.pool_full     = full;
  assign bus.pool_empty    = (outstanding_q == '0);
  assign bus.err_unexp_rsp = err_q;

endmodule
